// File: rtl/toggle_hs_rx.sv
// Two-phase (toggle) handshake receiver: synchronizes an async request,
// captures the sender's word into a small FIFO and toggles ack_t per word.
module toggle_hs_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_t,
    input  logic [WIDTH-1:0]           din,
    output logic                       ack_t,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic             sync1, sync2;
    logic [AW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pending, cap, rd;

    // Room is judged on the registered level, so a same-cycle read never
    // makes space for this cycle's capture.
    assign pending    = sync2 != ack_t;
    assign cap        = pending && (level < LW'(DEPTH));
    assign dout_valid = level != '0;
    assign rd         = dout_valid && dout_ready;
    assign dout       = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            ack_t <= 1'b0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            sync1 <= req_t;
            sync2 <= sync1;
            if (cap) begin
                wptr  <= wptr + 1'b1;
                ack_t <= ~ack_t;
            end
            if (rd)
                rptr <= rptr + 1'b1;
            case ({cap, rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is left unreset so it can map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (rst && cap)
            mem[wptr] <= din;
    end
endmodule

// File: tb/tb_toggle_hs_rx.sv
// Scoreboard bench for toggle_hs_rx: words queued when the sender drives
// them, popped and compared when the consumer takes them.
module tb_toggle_hs_rx;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   req_t;
    logic [WIDTH-1:0]       din;
    logic                   ack_t;
    logic [WIDTH-1:0]       dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic [$clog2(DEPTH):0] level;

    int n_chk = 0;
    int n_err = 0;
    int max_lvl = 0;
    logic [WIDTH-1:0] exp_q[$];

    toggle_hs_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_t(req_t), .din(din), .ack_t(ack_t),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer side: a word is taken on the next rising edge when valid&ready.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0)
                    chk("sb_underflow", exp_q.size(), 1);
                else
                    chk("dout_order", dout, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_t = 1'b0;
        dout_ready = 1'b0;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b1;
    endtask

    task automatic launch(input logic [WIDTH-1:0] d);
        din = d;
        req_t = ~req_t;
        exp_q.push_back(d);
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        bit done;
        done = 0;
        launch(d);
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            if (ack_t == req_t) done = 1;
        end
        if (!done) chk("ack_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        dout_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            if (level == 0) done = 1;
        end
        dout_ready = 1'b0;
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b0; req_t = 1'b0; din = '0; dout_ready = 1'b0;
        tick(); tick();
        chk("rst_ack", ack_t, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_level", level, 0);

        // Single word, 3-edge latency
        rst = 1'b1;
        launch(8'hA5);
        tick(); tick();
        chk("lat_ack_e1", ack_t, 0);
        chk("lat_valid_e1", dout_valid, 0);
        tick();
        chk("lat_ack_e2", ack_t, 1);
        chk("lat_valid_e2", dout_valid, 1);
        chk("lat_dout", dout, 8'hA5);
        chk("lat_level", level, 1);
        drain();
        chk("lat_sb_empty", exp_q.size(), 0);

        // Back-to-back fill to DEPTH
        do_reset();
        for (int i = 1; i <= 4; i++) send(WIDTH'(i));
        chk("b2b_level", level, 4);
        chk("b2b_ack", ack_t, 0);

        // Full stall, then one pop frees room
        launch(8'h05);
        repeat (5) tick();
        chk("full_ack_hold", ack_t, 0);
        chk("full_level", level, 4);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("full_pop_level", level, 3);
        chk("full_pop_ack", ack_t, 0);
        tick();
        chk("full_cap_ack", ack_t, 1);
        chk("full_cap_level", level, 4);
        drain();
        chk("full_sb_empty", exp_q.size(), 0);

        // Simultaneous capture and read
        do_reset();
        send(8'h01);
        send(8'h02);
        chk("sim_pre_level", level, 2);
        launch(8'h03);
        tick(); tick();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("sim_level", level, 2);
        chk("sim_ack", ack_t, 1);
        drain();
        chk("sim_sb_empty", exp_q.size(), 0);

        // Stream through with consumer always ready (pointer wrap)
        do_reset();
        dout_ready = 1'b1;
        max_lvl = 0;
        for (int i = 0; i < 10; i++) send(WIDTH'(8'h10 + i));
        repeat (4) tick();
        dout_ready = 1'b0;
        chk("wrap_sb_empty", exp_q.size(), 0);
        chk("wrap_max_level_le2", max_lvl <= 2, 1);
        chk("wrap_level", level, 0);

        // Reset mid-stream with a pending transfer
        do_reset();
        for (int i = 1; i <= 3; i++) send(WIDTH'(8'h20 + i));
        chk("mid_level", level, 3);
        launch(8'h24);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_ack", ack_t, 0);
        exp_q.delete();
        req_t = 1'b0;
        rst = 1'b1;
        repeat (4) tick();
        chk("mid_post_level", level, 0);
        chk("mid_post_ack", ack_t, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
